cam_capture: RTL and testbench

Camera-side writer into the frame buffer: receives an OV7670-style DVP stream and assembles RGB444 pixels from byte pairs. Writes each 12-bit pixel to a linear frame buffer address, 0..H*V-1, raster order. The VGA scan-out side reads these addresses. Runs entirely on the system clock. Camera pixel clock and strobes are synchronised and edge-detected, never used as a clock.

---
 rtl/cam_pkg.sv | 27 ++
 rtl/cam_capture_if.sv | 26 ++
 rtl/cam_sync.sv | 36 +++
 rtl/cam_capture.sv | 181 ++++++++++++++++++
 tb/tb_cam_capture.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path and the frame buffer scan-out side.
package cam_pkg;

  localparam int unsigned H_PIXELS_c = 640;
  localparam int unsigned V_LINES_c  = 480;
  localparam int unsigned FB_DEPTH_c = H_PIXELS_c * V_LINES_c;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2
  } cam_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Row/column counter width: holds the count and always exposes bits [8:5].
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w > 9) ? w : 9;
  endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera DVP input bundle and frame buffer write port of the capture block.
interface cam_capture_if #(
  parameter int unsigned ADDR_WIDTH_g = 19
) ();

  logic                    cam_pclk_i;
  logic                    cam_vsync_i;
  logic                    cam_href_i;
  logic [7:0]              cam_data_i;
  logic [ADDR_WIDTH_g-1:0] fb_addr_o;
  cam_pkg::rgb444_t        fb_data_o;
  logic                    fb_we_o;

  // Capture block side: consumes the camera stream, drives the frame buffer.
  modport master (
    input  cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i,
    output fb_addr_o, fb_data_o, fb_we_o
  );

  // Environment side: sensor model and frame buffer.
  modport slave (
    output cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i,
    input  fb_addr_o, fb_data_o, fb_we_o
  );

endinterface

// File: rtl/cam_sync.sv
// N-stage synchroniser with rising/falling edge detect on the synchronised value.
module cam_sync #(
  parameter int unsigned STAGES_g = 2,
  parameter int unsigned WIDTH_g  = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH_g-1:0] d_i,
  output logic [WIDTH_g-1:0] q_o,
  output logic [WIDTH_g-1:0] rise_c,
  output logic [WIDTH_g-1:0] fall_c
);

  logic [STAGES_g-1:0][WIDTH_g-1:0] stage_q, stage_d;
  logic [WIDTH_g-1:0]               prev_q, prev_d;

  always_comb begin
    stage_d = {stage_q[STAGES_g-2:0], d_i};
    prev_d  = stage_q[STAGES_g-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign q_o    = stage_q[STAGES_g-1];
  assign rise_c = q_o & ~prev_q;
  assign fall_c = ~q_o & prev_q;

endmodule

// File: rtl/cam_capture.sv
// DVP camera to RGB444 frame buffer writer, all logic on clk_i.
// Build option CAM_CAPTURE_TEST_PATTERN_EN replaces camera pixels with a row/column pattern.
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_PIXELS_g    = H_PIXELS_c,
  parameter int unsigned V_LINES_g     = V_LINES_c,
  parameter int unsigned ADDR_WIDTH_g  = 19,
  parameter int unsigned SYNC_STAGES_g = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          capture_en_i,
  cam_capture_if.master bus,
  output logic          frame_done_o,
  output logic          overflow_o,
  output logic          busy_o
);

  localparam logic [ADDR_WIDTH_g-1:0] FB_LAST = ADDR_WIDTH_g'(H_PIXELS_g * V_LINES_g - 1);
  localparam int unsigned COL_W = cnt_w(H_PIXELS_g);
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
  localparam int unsigned ROW_W = cnt_w(V_LINES_g);
`else
  localparam int unsigned ROW_W = 4;
`endif

  logic       pclk_rise_c, pclk_sync_unused, pclk_fall_unused;
  logic       vsync_rise_c, vsync_fall_c, vsync_sync_unused;
  logic       href_sync, href_fall_c, href_rise_unused;
  logic [7:0] data_sync, data_rise_unused, data_fall_unused;

  cam_sync #(.STAGES_g(SYNC_STAGES_g), .WIDTH_g(1)) u_sync_pclk (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(bus.cam_pclk_i),
    .q_o(pclk_sync_unused), .rise_c(pclk_rise_c), .fall_c(pclk_fall_unused)
  );

  cam_sync #(.STAGES_g(SYNC_STAGES_g), .WIDTH_g(1)) u_sync_vsync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(bus.cam_vsync_i),
    .q_o(vsync_sync_unused), .rise_c(vsync_rise_c), .fall_c(vsync_fall_c)
  );

  cam_sync #(.STAGES_g(SYNC_STAGES_g), .WIDTH_g(1)) u_sync_href (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(bus.cam_href_i),
    .q_o(href_sync), .rise_c(href_rise_unused), .fall_c(href_fall_c)
  );

  // Same depth as pclk so the byte lines up with its sample event.
  cam_sync #(.STAGES_g(SYNC_STAGES_g), .WIDTH_g(8)) u_sync_data (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(bus.cam_data_i),
    .q_o(data_sync), .rise_c(data_rise_unused), .fall_c(data_fall_unused)
  );

  cam_state_e              state_q, state_d;
  logic [ADDR_WIDTH_g-1:0] addr_q, addr_d;
  rgb444_t                 data_q, data_d;
  logic                    we_q, we_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;
  logic                    full_q, full_d;
  logic                    phase_q, phase_d;
  logic [3:0]              red_q, red_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    pix_c;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    full_d  = full_q;
    phase_d = phase_q;
    red_d   = red_q;
    col_d   = col_q;
    row_d   = row_q;
    pix_c   = 1'b0;

    // Address advances the cycle after a write, and pins at the last location.
    if (we_q) begin
      if (addr_q == FB_LAST) full_d = 1'b1;
      else                   addr_d = addr_q + ADDR_WIDTH_g'(1);
    end

    case (state_q)
      IDLE: begin
        if (capture_en_i) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (vsync_fall_c) begin
          addr_d  = '0;
          full_d  = 1'b0;
          phase_d = 1'b0;
          col_d   = '0;
          row_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (pclk_rise_c && href_sync) begin
          if (!phase_q) begin
            red_d   = data_sync[3:0];
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            pix_c   = 1'b1;
          end
        end
        if (href_fall_c) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end
        // Frame end; capture_en_i only matters here, never mid-frame.
        if (vsync_rise_c) begin
          done_d  = 1'b1;
          state_d = capture_en_i ? WAIT_SOF : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!href_sync) phase_d = 1'b0;

    if (pix_c) begin
      if (full_d) begin
        ovf_d = 1'b1;
      end else begin
        we_d  = 1'b1;
        col_d = col_q + COL_W'(1);
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        data_d = rgb444_t'({col_q[8:5], row_q[8:5], col_q[3:0] ^ row_q[3:0]});
`else
        data_d = '{r: red_q, g: data_sync[7:4], b: data_sync[3:0]};
`endif
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      phase_q <= 1'b0;
      red_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
      phase_q <= phase_d;
      red_q   <= red_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign bus.fb_addr_o = addr_q;
  assign bus.fb_data_o = data_q;
  assign bus.fb_we_o   = we_q;
  assign frame_done_o  = done_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: small frames driven through a DVP byte model.
module tb_cam_capture;
  import cam_pkg::*;

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
  localparam int unsigned H = 40, V = 2, AW = 7;
`else
  localparam int unsigned H = 2, V = 2, AW = 4;
`endif

  logic clk = 1'b0;
  logic rst, cap_en;
  logic frame_done, overflow, busy;

  always #5 clk = ~clk;

  cam_capture_if #(.ADDR_WIDTH_g(AW)) bus ();

  cam_capture #(
    .H_PIXELS_g(H), .V_LINES_g(V), .ADDR_WIDTH_g(AW), .SYNC_STAGES_g(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .capture_en_i(cap_en), .bus(bus),
    .frame_done_o(frame_done), .overflow_o(overflow), .busy_o(busy)
  );

  typedef logic [7:0] byte_q_t[$];
  typedef int unsigned uint_q_t[$];

  int unsigned n_vec = 0, n_err = 0;
  int unsigned cyc = 0, rise_cyc = 0, done_cnt = 0;
  logic        done_we = 1'b0;
  uint_q_t     wr_addr, wr_data, wr_lat;
  byte_q_t     bq;
  uint_q_t     ea, ed;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write and frame_done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.fb_we_o) begin
      wr_addr.push_back(int'(bus.fb_addr_o));
      wr_data.push_back(int'(bus.fb_data_o));
      wr_lat.push_back(cyc - rise_cyc);
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_we  = bus.fb_we_o;
    end
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    bus.cam_data_i = b;
    tick(4);
    bus.cam_pclk_i = 1'b1;
    rise_cyc = cyc;
    tick(4);
    bus.cam_pclk_i = 1'b0;
  endtask

  task automatic send_line(input byte_q_t q);
    bus.cam_href_i = 1'b1;
    tick(4);
    foreach (q[i]) cam_byte(q[i]);
    tick(4);
    bus.cam_href_i = 1'b0;
    tick(8);
  endtask

  task automatic frame_start();
    bus.cam_vsync_i = 1'b1;
    tick(8);
    bus.cam_vsync_i = 1'b0;
    tick(8);
  endtask

  task automatic frame_end();
    bus.cam_vsync_i = 1'b1;
    tick(8);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_lat.delete();
    done_cnt = 0;
    done_we  = 1'b0;
  endtask

  task automatic check_log(input string tag, input uint_q_t a, input uint_q_t d);
    check_eq({tag, " wr_count"}, wr_addr.size(), a.size());
    for (int i = 0; i < a.size() && i < wr_addr.size(); i++) begin
      check_eq($sformatf("%s addr[%0d]", tag, i), wr_addr[i], a[i]);
      check_eq($sformatf("%s data[%0d]", tag, i), wr_data[i], d[i]);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, " fb_addr"}, int'(bus.fb_addr_o), 0);
    check_eq({tag, " fb_data"}, int'(bus.fb_data_o), 0);
    check_eq({tag, " fb_we"}, int'(bus.fb_we_o), 0);
    check_eq({tag, " frame_done"}, int'(frame_done), 0);
    check_eq({tag, " overflow"}, int'(overflow), 0);
    check_eq({tag, " busy"}, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    cap_en = 1'b0;
    bus.cam_pclk_i  = 1'b0;
    bus.cam_vsync_i = 1'b1;
    bus.cam_href_i  = 1'b0;
    bus.cam_data_i  = 8'h00;
    tick(3);
    check_reset("reset");
    rst = 1'b0;
    tick(2);
    cap_en = 1'b1;
    tick(1);
    check_eq("arm busy", int'(busy), 1);

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    clear_log();
    frame_start();
    bq = {};
    for (int i = 0; i < 80; i++) bq.push_back(8'h00);
    send_line(bq);
    bq = {};
    for (int i = 0; i < 68; i++) bq.push_back(8'hFF);
    send_line(bq);
    frame_end();
    check_eq("pat wr_count", wr_addr.size(), 74);
    if (wr_addr.size() == 74) begin
      check_eq("pat r0c0 data", wr_data[0], 12'h000);
      check_eq("pat r0c33 data", wr_data[33], 12'h101);
      check_eq("pat r1c0 addr", wr_addr[40], 40);
      check_eq("pat r1c0 data", wr_data[40], 12'h001);
      check_eq("pat r1c33 addr", wr_addr[73], 73);
      check_eq("pat r1c33 data", wr_data[73], 12'h100);
    end
    check_eq("pat frame_done", done_cnt, 1);
`else
    // 2x2 frame of 0xABC pixels
    clear_log();
    frame_start();
    bq = {8'h0A, 8'hBC, 8'h0A, 8'hBC};
    send_line(bq);
    send_line(bq);
    frame_end();
    ea = {0, 1, 2, 3};
    ed = {12'hABC, 12'hABC, 12'hABC, 12'hABC};
    check_log("t1", ea, ed);
    if (wr_lat.size() > 0) check_eq("t1 we latency", wr_lat[0], 3);
    check_eq("t1 frame_done", done_cnt, 1);
    check_eq("t1 overflow", int'(overflow), 0);
    check_eq("t1 addr hold", int'(bus.fb_addr_o), 3);
    check_eq("t1 busy", int'(busy), 1);

    // odd trailing byte dropped, next line re-pairs from phase 0
    clear_log();
    frame_start();
    bq = {8'h05, 8'h67, 8'h09};
    send_line(bq);
    bq = {8'h01, 8'h23};
    send_line(bq);
    frame_end();
    ea = {0, 1};
    ed = {12'h567, 12'h123};
    check_log("t2", ea, ed);

    // H*V+3 pixels, capture_en dropped mid-frame
    clear_log();
    frame_start();
    cap_en = 1'b0;
    bq = {};
    for (int i = 0; i < 7; i++) begin
      bq.push_back(8'(i));
      bq.push_back(8'(8'h20 + i));
    end
    send_line(bq);
    frame_end();
    ea = {0, 1, 2, 3};
    ed = {12'h020, 12'h121, 12'h222, 12'h323};
    check_log("t3", ea, ed);
    check_eq("t3 overflow", int'(overflow), 1);
    check_eq("t3 addr hold", int'(bus.fb_addr_o), 3);
    check_eq("t3 frame_done", done_cnt, 1);
    check_eq("t3 busy idle", int'(busy), 0);

    // disarmed frame, then arm mid-frame
    clear_log();
    frame_start();
    bq = {8'h0A, 8'hBC, 8'h0A, 8'hBC};
    send_line(bq);
    frame_end();
    check_eq("t4 idle writes", wr_addr.size(), 0);
    check_eq("t4 idle busy", int'(busy), 0);
    check_eq("t4 idle done", done_cnt, 0);
    frame_start();
    cap_en = 1'b1;
    bq = {8'h0A, 8'hBC};
    send_line(bq);
    frame_end();
    check_eq("t4 armed midframe writes", wr_addr.size(), 0);
    check_eq("t4 armed busy", int'(busy), 1);
    frame_start();
    bq = {8'h0D, 8'hEF};
    send_line(bq);
    frame_end();
    ea = {0};
    ed = {12'hDEF};
    check_log("t4", ea, ed);
    check_eq("t4 overflow sticky", int'(overflow), 1);

    // reset in the middle of a line
    clear_log();
    frame_start();
    bus.cam_href_i = 1'b1;
    tick(4);
    cam_byte(8'h0A);
    cam_byte(8'hBC);
    cam_byte(8'h0C);
    check_eq("t5 pre-reset writes", wr_addr.size(), 1);
    rst = 1'b1;
    tick(1);
    check_reset("t5 midline reset");
    rst = 1'b0;
    clear_log();
    cam_byte(8'hDE);
    tick(4);
    bus.cam_href_i = 1'b0;
    tick(8);
    frame_end();
    check_eq("t5 post-reset writes", wr_addr.size(), 0);
    frame_start();
    bq = {8'h01, 8'h23};
    send_line(bq);
    frame_end();
    ea = {0};
    ed = {12'h123};
    check_log("t5", ea, ed);

    // vsync rises in the same cycle a pixel completes
    clear_log();
    frame_start();
    bus.cam_href_i = 1'b1;
    tick(4);
    cam_byte(8'h0A);
    bus.cam_data_i = 8'hBC;
    tick(4);
    bus.cam_pclk_i  = 1'b1;
    bus.cam_vsync_i = 1'b1;
    rise_cyc = cyc;
    tick(4);
    bus.cam_pclk_i = 1'b0;
    tick(4);
    bus.cam_href_i = 1'b0;
    tick(8);
    ea = {0};
    ed = {12'hABC};
    check_log("t6", ea, ed);
    check_eq("t6 frame_done", done_cnt, 1);
    check_eq("t6 done with we", int'(done_we), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
